// File: rtl/div_pkg.sv
// Shared definitions for the signed-division control block.
//   div_state_e : FSM state encoding (IDLE / WAIT / DONE)
//   DEF_WIDTH   : default operand/result width
//   DEF_SETTLE  : default divider settle time in clock edges (legal 1..15)
//   MIN_NEG     : most negative two's-complement value at the default width
package div_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_SETTLE = 2;
  localparam logic [DEF_WIDTH-1:0] MIN_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned wrapper around an external unsigned divider.
// Converts operands to magnitudes, waits SETTLE edges for the divider,
// then sign-corrects the quotient (LO) and remainder (HI).
//
// Handshake: start is sampled only while ready=1 (state IDLE); the edge that
// samples it is the accept edge, after which the operand inputs are ignored.
// done pulses for exactly one cycle when lo_out/hi_out have been updated.
//
// Ports:
//   clk, clr             clock (rising edge), async active-high reset
//   start, signed_op     request / signedness of the operation
//   dividend_in/divisor_in operands
//   ready                idle, start will be accepted
//   div_a, div_b         registered magnitudes to the unsigned divider
//   div_q, div_r         unsigned quotient/remainder from the divider
//   lo_out, hi_out       signed-corrected quotient / remainder
//   done                 one-cycle completion pulse
//   div_by_zero,overflow sticky status of the last accepted operation
module div_sign_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE   // legal range 1..15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             ready,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement magnitude; the minimum value maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic sa, sb;
  logic settle_end;

  assign accept     = (state_q == ST_IDLE) && start;
  assign sa         = signed_op && dividend_in[WIDTH-1];
  assign sb         = signed_op && divisor_in[WIDTH-1];
  assign settle_end = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (divisor_in == '0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    if (accept) begin
      div_a_d = signed_op ? abs_val(dividend_in) : dividend_in;
      div_b_d = signed_op ? abs_val(divisor_in)  : divisor_in;
      // sa/sb are already gated by signed_op, so unsigned ops never negate.
      q_neg_d = sa ^ sb;
      r_neg_d = sa;
      cnt_d   = '0;
      dbz_d   = 1'b0;
      ovf_d   = signed_op && (dividend_in == MIN_VAL) && (divisor_in == '1);
      // Divide-by-zero skips the divider entirely and completes on this edge.
      if (divisor_in == '0) begin
        lo_d  = '1;
        hi_d  = dividend_in;
        dbz_d = 1'b1;
      end
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 4'd1;
      if (settle_end) begin
        lo_d = q_neg_q ? (~div_q + 1'b1) : div_q;
        hi_d = r_neg_q ? (~div_r + 1'b1) : div_r;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign lo_out      = lo_q;
  assign hi_out      = hi_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl (WIDTH=32, SETTLE=2). The bench plays the
// parent: it models the unsigned divider as one register stage so its result
// is only valid from the second edge after div_a/div_b change.
// Edge counts below are taken from the moment start is raised, so they
// include the accept edge: normal ops complete on edge SETTLE+1 = 3,
// divide-by-zero on edge 1.
module tb_div_sign_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic         ready;
  logic [W-1:0] div_a, div_b, div_q, div_r;
  logic [W-1:0] lo_out, hi_out;
  logic         done, div_by_zero, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sign_ctrl #(.WIDTH(W), .SETTLE(2)) dut (
    .clk(clk), .clr(clr), .start(start), .signed_op(signed_op),
    .dividend_in(dividend_in), .divisor_in(divisor_in), .ready(ready),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .lo_out(lo_out), .hi_out(hi_out), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Unsigned divider model, one register of latency.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q <= '0;
      div_r <= '0;
    end else if (div_b == '0) begin
      div_q <= 32'h0BAD_0BAD;
      div_r <= 32'h0BAD_0BAD;
    end else begin
      div_q <= div_a / div_b;
      div_r <= div_a % div_b;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges; gives up after 10 edges.
  task automatic wait_done(inout int edges);
    while (!done && edges < 10) begin
      tick();
      edges++;
    end
  endtask

  // One complete operation: raise start, check captured magnitudes on the
  // accept edge, scramble the inputs, wait for done and check results.
  task automatic run_op(input string tag, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input int exp_edges,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic edbz, input logic eovf);
    int edges;
    start = 1'b1; signed_op = sg; dividend_in = a; divisor_in = b;
    tick();
    edges = 1;
    start = 1'b0;
    signed_op = ~sg;
    dividend_in = $urandom_range(1000, 60000);
    divisor_in  = $urandom_range(1, 50);
    chk({tag, "_div_a"}, div_a, ea);
    chk({tag, "_div_b"}, div_b, eb);
    wait_done(edges);
    chk({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_lo"}, lo_out, elo);
    chk({tag, "_hi"}, hi_out, ehi);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
    tick();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_lo_hold"}, lo_out, elo);
    chk({tag, "_dbz_sticky"}, {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    int edges;
    int seen;
    clr = 1'b1; start = 1'b0; signed_op = 1'b0;
    dividend_in = '0; divisor_in = '0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    #11;
    clr = 1'b0;
    tick();

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 3, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 3,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 3,
           32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'd0, 1,
           32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    run_op("s_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, 32'd8, 32'd0, 1,
           32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 1'b0);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 3,
           32'h8000_0000, 32'd0, 1'b0, 1'b1);
    run_op("u_min_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 3,
           32'd0, 32'h8000_0000, 1'b0, 1'b0);

    // Second start during WAIT is ignored.
    start = 1'b1; signed_op = 1'b0; dividend_in = 32'd20; divisor_in = 32'd3;
    tick();
    edges = 1;
    dividend_in = 32'd50; divisor_in = 32'd5;
    tick();
    edges++;
    start = 1'b0;
    chk("wait_start_div_a", div_a, 32'd20);
    chk("wait_start_div_b", div_b, 32'd3);
    wait_done(edges);
    chk("wait_start_edges", 32'(edges), 32'd3);
    chk("wait_start_lo", lo_out, 32'd6);
    chk("wait_start_hi", hi_out, 32'd2);
    tick();

    // Start held across DONE: accepted only in the following IDLE cycle.
    start = 1'b1; signed_op = 1'b0; dividend_in = 32'd9; divisor_in = 32'd4;
    tick();
    edges = 1;
    dividend_in = 32'd17; divisor_in = 32'd5;
    wait_done(edges);
    chk("held_edges", 32'(edges), 32'd3);
    chk("held_lo1", lo_out, 32'd2);
    chk("held_hi1", hi_out, 32'd1);
    tick();
    chk("held_idle_ready", {31'd0, ready}, 32'd1);
    chk("held_idle_div_a", div_a, 32'd9);
    tick();
    edges = 1;
    start = 1'b0;
    chk("held_acc_ready", {31'd0, ready}, 32'd0);
    chk("held_acc_div_a", div_a, 32'd17);
    wait_done(edges);
    chk("held_edges2", 32'(edges), 32'd3);
    chk("held_lo2", lo_out, 32'd3);
    chk("held_hi2", hi_out, 32'd2);
    tick();

    // clr mid-WAIT aborts with no done pulse and clears outputs at once.
    start = 1'b1; signed_op = 1'b0; dividend_in = 32'd100; divisor_in = 32'd7;
    tick();
    start = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_ready", {31'd0, ready}, 32'd1);
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_lo", lo_out, 32'd0);
    chk("clr_hi", hi_out, 32'd0);
    chk("clr_div_ab", div_a | div_b, 32'd0);
    chk("clr_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    tick();
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen++;
    end
    chk("clr_no_done", 32'(seen), 32'd0);
    run_op("after_clr_9_3", 1'b0, 32'd9, 32'd3, 32'd9, 32'd3, 3,
           32'd3, 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
